audio_decim_framer: RTL and testbench

//  Consumes the FIR low-pass stream (filtered_audio/data_ready) and decimates it by DECIM.

---
 rtl/audio_decim_framer.sv | 145 ++++++++++++++
 tb/tb_audio_decim_framer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_decim_framer.sv
// Decimates the FIR stream, keeps the kept samples in a circular buffer and
// streams out overlapping oldest-first frames over valid/ready.
//   state  | meaning
//   IDLE   | waiting for a frame trigger
//   STREAM | reading one frame out of the buffer
module audio_decim_framer #(
    parameter int WIDTH     = 16,
    parameter int DECIM     = 4,
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic signed [WIDTH-1:0]        audio_in,
    input  logic                           valid_in,
    output logic signed [WIDTH-1:0]        frame_out,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic                           frame_last,
    output logic [$clog2(FRAME_LEN)-1:0]   frame_index,
    output logic                           overflow
);
    localparam int AW  = $clog2(FRAME_LEN);
    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int HW  = $clog2(HOP + 1);
    localparam logic [AW:0]     FL     = (AW+1)'(FRAME_LEN);
    localparam logic [AW-1:0]   LAST_K = AW'(FRAME_LEN - 1);
    localparam logic [DCW-1:0]  DC_MAX = DCW'(DECIM - 1);
    localparam logic [HW-1:0]   HOP_N  = HW'(HOP);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  r_state, w_state_next;
    logic [DCW-1:0]          r_dcnt;
    logic [AW-1:0]           r_wp, r_start, r_xfer_k, r_q_k, r_out_k;
    logic [AW:0]             r_rd_k;
    logic [HW-1:0]           r_hop;
    logic                    r_primed, r_q_v, r_out_v, r_out_last, r_ovf;
    logic signed [WIDTH-1:0] r_mem [FRAME_LEN];
    logic signed [WIDTH-1:0] r_q, r_out;

    logic                    w_accept, w_prime_now, w_trigger, w_start_frame;
    logic                    w_hs, w_last_hs, w_out_take, w_q_take, w_rd_en;
    logic                    w_ovf_a, w_ovf_b;
    logic [AW-1:0]           w_wp_next, w_rd_addr, w_m;
    logic [HW-1:0]           w_hop_next;
    logic [AW:0]             w_xfer_next;

    assign w_accept    = valid_in && (r_dcnt == '0);
    assign w_wp_next   = r_wp + 1'b1;
    assign w_hop_next  = r_hop + 1'b1;
    assign w_prime_now = !r_primed && (r_wp == LAST_K);
    assign w_trigger   = w_accept && (w_prime_now || (r_primed && (w_hop_next == HOP_N)));

    // Two-stage read path: RAM output register, then the output beat register.
    assign w_hs       = r_out_v && frame_ready;
    assign w_last_hs  = w_hs && (r_out_k == LAST_K);
    assign w_out_take = !r_out_v || frame_ready;
    assign w_q_take   = !r_q_v || w_out_take;
    assign w_rd_en    = (r_state == STREAM) && (r_rd_k != FL) && w_q_take;
    assign w_rd_addr  = r_start + r_rd_k[AW-1:0];

    // A write at frame offset m is a loss if beat m has not left by this edge.
    assign w_m         = r_wp - r_start;
    assign w_xfer_next = {1'b0, r_xfer_k} + (AW+1)'(w_hs);
    assign w_ovf_b     = w_accept && (r_state == STREAM) && ({1'b0, w_m} >= w_xfer_next);
    assign w_ovf_a     = w_trigger && (r_state == STREAM);

    always_comb begin
        w_state_next  = r_state;
        w_start_frame = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_next  = STREAM;
                    w_start_frame = 1'b1;
                end
            end
            STREAM: begin
                if (w_last_hs) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) r_mem[r_wp] <= audio_in;
        if (w_rd_en)  r_q <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_dcnt     <= '0;
            r_wp       <= '0;
            r_hop      <= '0;
            r_primed   <= 1'b0;
            r_start    <= '0;
            r_rd_k     <= '0;
            r_xfer_k   <= '0;
            r_q_v      <= 1'b0;
            r_q_k      <= '0;
            r_out_v    <= 1'b0;
            r_out      <= '0;
            r_out_k    <= '0;
            r_out_last <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (valid_in) r_dcnt <= (r_dcnt == DC_MAX) ? '0 : r_dcnt + 1'b1;
            if (w_accept) begin
                r_wp  <= w_wp_next;
                r_hop <= w_trigger ? '0 : w_hop_next;
                if (w_prime_now) r_primed <= 1'b1;
            end
            if (w_start_frame) begin
                r_start  <= w_wp_next;
                r_rd_k   <= '0;
                r_xfer_k <= '0;
            end else begin
                if (w_rd_en) r_rd_k   <= r_rd_k + 1'b1;
                if (w_hs)    r_xfer_k <= r_xfer_k + 1'b1;
            end
            if (w_q_take) begin
                r_q_v <= w_rd_en;
                if (w_rd_en) r_q_k <= r_rd_k[AW-1:0];
            end
            if (w_out_take) begin
                r_out_v    <= r_q_v;
                r_out_last <= r_q_v && (r_q_k == LAST_K);
                if (r_q_v) begin
                    r_out   <= r_q;
                    r_out_k <= r_q_k;
                end
            end
            r_ovf <= w_ovf_a || w_ovf_b;
        end
    end

    assign frame_out   = r_out;
    assign frame_valid = r_out_v;
    assign frame_last  = r_out_last;
    assign frame_index = r_out_k;
    assign overflow    = r_ovf;
endmodule

// File: tb/tb_audio_decim_framer.sv
// Directed bench: instance A (DECIM=2, HOP=4) and B (DECIM=1, HOP=8) share
// all inputs; frames are collected at the negative edge and checked.
module tb_audio_decim_framer;
    typedef struct packed {
        logic signed [15:0] d;
        logic [2:0]         i;
        logic               l;
    } beat_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic               rst_in, valid_in, frame_ready;
    logic signed [15:0] audio_in;
    logic signed [15:0] out_a, out_b;
    logic               fv_a, fv_b, last_a, last_b, ovf_a_sig, ovf_b_sig;
    logic [2:0]         idx_a, idx_b;

    audio_decim_framer #(.WIDTH(16), .DECIM(2), .FRAME_LEN(8), .HOP(4)) u_a (
        .clk_in(clk_in), .rst_in(rst_in), .audio_in(audio_in), .valid_in(valid_in),
        .frame_out(out_a), .frame_valid(fv_a), .frame_ready(frame_ready),
        .frame_last(last_a), .frame_index(idx_a), .overflow(ovf_a_sig));

    audio_decim_framer #(.WIDTH(16), .DECIM(1), .FRAME_LEN(8), .HOP(8)) u_b (
        .clk_in(clk_in), .rst_in(rst_in), .audio_in(audio_in), .valid_in(valid_in),
        .frame_out(out_b), .frame_valid(fv_b), .frame_ready(frame_ready),
        .frame_last(last_b), .frame_index(idx_b), .overflow(ovf_b_sig));

    int    n_vec = 0, n_err = 0, cyc = 0;
    int    ovf_a = 0, ovf_b = 0, first_ovf_a = -1, acc7_b = -1, acc16_a = -1, rise_b = -1;
    bit    bp_mode = 1'b0, stall_a = 1'b0, fv_b_q = 1'b0;
    logic [15:0] pat = 16'b1101_1000_1110_1111;
    beat_t prev_a, t;
    beat_t qa[$], qb[$];

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial forever begin
        @(negedge clk_in);
        if (rst_in) begin
            stall_a = 1'b0;
            fv_b_q  = 1'b0;
        end else begin
            if (stall_a) begin
                n_vec++;
                assert (fv_a === 1'b1 && out_a === prev_a.d && idx_a === prev_a.i && last_a === prev_a.l)
                else begin
                    n_err++;
                    $error("FAIL stall_hold: observed %h expected %h", {fv_a, out_a, idx_a, last_a}, {1'b1, prev_a});
                end
            end
            stall_a  = fv_a && !frame_ready;
            prev_a.d = out_a; prev_a.i = idx_a; prev_a.l = last_a;
            if (fv_a && frame_ready) begin
                t.d = out_a; t.i = idx_a; t.l = last_a; qa.push_back(t);
            end
            if (fv_b && frame_ready) begin
                t.d = out_b; t.i = idx_b; t.l = last_b; qb.push_back(t);
            end
            if (ovf_a_sig) begin
                ovf_a++;
                if (first_ovf_a < 0) first_ovf_a = cyc;
            end
            if (ovf_b_sig) ovf_b++;
            if (valid_in && audio_in == 16'sd7 && acc7_b < 0) acc7_b = cyc + 1;
            if (valid_in && audio_in == 16'sd16 && acc16_a < 0) acc16_a = cyc + 1;
            if (fv_b && !fv_b_q && rise_b < 0) rise_b = cyc;
            fv_b_q = fv_b;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_beat(input string tag, input beat_t b, input int d, input int k);
        chk({tag, "_data"}, b.d, d);
        chk({tag, "_index"}, b.i, k);
        chk({tag, "_last"}, b.l, (k == 7) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (bp_mode) frame_ready = pat[cyc % 16];
    endtask

    task automatic do_reset();
        rst_in = 1'b1; valid_in = 1'b0; audio_in = '0; frame_ready = 1'b1; bp_mode = 1'b0;
        repeat (2) tick();
        chk("rst_frame_out", out_a, 0);
        chk("rst_frame_valid", fv_a, 0);
        chk("rst_frame_last", last_a, 0);
        chk("rst_frame_index", idx_a, 0);
        chk("rst_overflow", ovf_a_sig, 0);
        rst_in = 1'b0;
        qa.delete(); qb.delete();
        ovf_a = 0; ovf_b = 0; first_ovf_a = -1; acc7_b = -1; acc16_a = -1; rise_b = -1;
    endtask

    task automatic feed_ramp(input int n, input int period, input int base);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1;
            audio_in = 16'(base + i);
            tick();
            valid_in = 1'b0;
            repeat (period - 1) tick();
        end
    endtask

    initial begin
        int w, lasts;
        logic signed [15:0] vals [3];
        vals[0] = -16'sd32768; vals[1] = 16'sd32767; vals[2] = -16'sd1;

        // Ramp, DECIM=2/HOP=4 on A and DECIM=1/HOP=8 on B concurrently
        do_reset();
        feed_ramp(32, 3, 0);
        repeat (30) tick();
        chk("t1_beats_a", qa.size(), 24);
        for (int k = 0; k < 24 && k < qa.size(); k++) chk_beat("t1_a", qa[k], 8 * (k / 8) + 2 * (k % 8), k % 8);
        chk("t1_overflow_a", ovf_a, 0);
        chk("t2_beats_b", qb.size(), 32);
        for (int k = 0; k < 32 && k < qb.size(); k++) chk_beat("t2_b", qb[k], k, k % 8);
        chk("t2_overflow_b", ovf_b, 0);
        chk("t2_valid_latency", rise_b, acc7_b + 2);

        // Backpressure with low runs of at most 3 cycles
        do_reset();
        bp_mode = 1'b1;
        feed_ramp(32, 3, 0);
        repeat (40) tick();
        bp_mode = 1'b0; frame_ready = 1'b1;
        chk("t3_beats_a", qa.size(), 24);
        for (int k = 0; k < 24 && k < qa.size(); k++) chk_beat("t3_a", qa[k], 8 * (k / 8) + 2 * (k % 8), k % 8);
        chk("t3_overflow_a", ovf_a, 0);

        // Overflow: stalled frame overwritten, then a dropped trigger
        do_reset();
        frame_ready = 1'b0;
        feed_ramp(24, 1, 0);
        repeat (4) tick();
        chk("t4_overflow_pulses", ovf_a, 4);
        chk("t4_first_overflow_cycle", first_ovf_a, acc16_a);
        chk("t4_no_transfer_while_stalled", qa.size(), 0);
        frame_ready = 1'b1;
        repeat (20) tick();
        chk("t4_beats_after_release", qa.size(), 8);
        lasts = 0;
        for (int k = 0; k < qa.size(); k++) begin
            if (k < 8) chk("t4_index", qa[k].i, k);
            lasts += int'(qa[k].l);
        end
        chk("t4_last_count", lasts, 1);
        chk("t4_valid_idle", fv_a, 0);
        chk("t4_overflow_total", ovf_a, 4);

        // Signed extremes through B
        do_reset();
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            audio_in = vals[i % 3];
            tick();
        end
        valid_in = 1'b0;
        repeat (15) tick();
        chk("t5_beats_b", qb.size(), 8);
        for (int k = 0; k < 8 && k < qb.size(); k++) chk_beat("t5_b", qb[k], int'(vals[k % 3]), k);
        chk("t5_a_not_primed", qa.size(), 0);

        // Asynchronous reset at beat 3, then re-prime from scratch
        do_reset();
        feed_ramp(15, 3, 0);
        w = 0;
        while (!(fv_a === 1'b1 && idx_a === 3'd3) && w < 50) begin
            tick();
            w++;
        end
        chk("t6_reach_beat3", (w < 50) ? 1 : 0, 1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6_async_frame_out", out_a, 0);
        chk("t6_async_frame_valid", fv_a, 0);
        chk("t6_async_frame_last", last_a, 0);
        chk("t6_async_frame_index", idx_a, 0);
        chk("t6_async_overflow", ovf_a_sig, 0);
        repeat (2) tick();
        rst_in = 1'b0;
        qa.delete();
        feed_ramp(16, 3, 100);
        repeat (15) tick();
        chk("t6_beats_a", qa.size(), 8);
        for (int k = 0; k < 8 && k < qa.size(); k++) chk_beat("t6_a", qa[k], 100 + 2 * k, k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
